// File: rtl/div32_seq.sv
// Sequential restoring divider: 32 quotient bits MSB first, then a sign-fix cycle; done 34 edges after start.
// Signed two's-complement support is compiled in with DIV_SIGNED_EN; otherwise all divisions are unsigned.
module div32_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd_l, dvs_l;
   logic             sgn_l;
   logic [WIDTH-1:0] dvs_m, rem, dq;
   logic [WIDTH-1:0] mag_a, mag_b, fix_q, fix_r;
   logic [WIDTH:0]   shifted, diff;
   logic             ld;

   assign ld      = start && (state == IDLE || state == DONE);
   assign shifted = {rem, dq[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_m};
   assign busy    = (state == CALC) || (state == FIX);
   assign done    = (state == DONE);

`ifdef DIV_SIGNED_EN
   logic neg_a, neg_b;
   assign neg_a = sgn_l & dvd_l[WIDTH-1];
   assign neg_b = sgn_l & dvs_l[WIDTH-1];
   assign mag_a = neg_a ? -dvd_l : dvd_l;
   assign mag_b = neg_b ? -dvs_l : dvs_l;
   assign fix_q = (neg_a ^ neg_b) ? -dq : dq;
   assign fix_r = neg_a ? -rem : rem;
`else
   logic unused_sign;
   assign unused_sign = sign ^ sgn_l;
   assign mag_a = dvd_l;
   assign mag_b = dvs_l;
   assign fix_q = dq;
   assign fix_r = rem;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (cnt == CW'(WIDTH)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = start ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cnt==0 is a setup cycle that forms the magnitudes; cnt 1..WIDTH each retire one quotient bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         dvd_l       <= '0;
         dvs_l       <= '0;
         sgn_l       <= 1'b0;
         dvs_m       <= '0;
         rem         <= '0;
         dq          <= '0;
         q           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         if (ld) begin
            dvd_l <= dividend;
            dvs_l <= divisor;
            sgn_l <= sign;
            cnt   <= '0;
         end
         case (state)
            CALC: begin
               cnt <= cnt + 1'b1;
               if (cnt == '0) begin
                  dq    <= mag_a;
                  dvs_m <= mag_b;
                  rem   <= '0;
               end else if (!diff[WIDTH]) begin
                  rem <= diff[WIDTH-1:0];
                  dq  <= {dq[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH-1:0];
                  dq  <= {dq[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               // Divide by zero reports the raw dividend, bypassing sign correction.
               if (dvs_l == '0) begin
                  q           <= '1;
                  r           <= dvd_l;
                  div_by_zero <= 1'b1;
               end else begin
                  q           <= fix_q;
                  r           <= fix_r;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
